irda_fir_lppm_decoder: RTL and testbench
========================================

Name: irda_fir_lppm_decoder

Overview:
Parametrised L-PPM chip-to-bit decoder for the FIR receive path. It sits after the chip slicer and replaces the fixed 4PPM decoder.
- Collects CHIPS chips per symbol and decodes the one-hot chip pattern to a SYM_BITS-wide symbol.
- Flags and counts illegal chip patterns.
- Presents the data both as a parallel symbol and as a serial bit stream in a selectable bit order.

Parameters:
CHIPS, 4, chips per symbol; power of two, range 2..16 (4 = IrDA 4PPM, 16 = 16PPM)
SYM_BITS, log2(CHIPS), derived localparam, bits per symbol; not overridable
ERR_W, 8, width of the saturating bad-symbol counter

Ports:
clk  in  1  system clock (single clock domain)
wb_rst_i  in  1  reset, synchronous, active-high
chip_en  in  1  chip-rate strobe, one clk wide; all state advances only on it
ppmd_restart  in  1  symbol realign; current fd_o is chip 0 of a new symbol
fd_o  in  1  sliced chip value
lsb_first  in  1  serial order: 1 = LSB first (IrDA), 0 = MSB first; sampled at symbol decode
bad_cnt_clr  in  1  clears bad_cnt
ppmd_sym  out  SYM_BITS  last decoded symbol
ppmd_sym_valid  out  1  one-clk pulse, ppmd_sym updated
ppmd_bad_chip  out  1  one-clk pulse with ppmd_sym_valid when the pattern was not one-hot
ppmd_o  out  1  serial data bit
ppmd_bit_valid  out  1  one-clk pulse, ppmd_o updated
bad_cnt  out  ERR_W  saturating count of bad symbols

Behaviour:
- Reset (wb_rst_i=1 at a clk edge): all registers and outputs go to 0. This includes chip_cnt, the chip buffer, the serial shifter, bits_left and bad_cnt. Reset overrides every other input.
- chip_cnt (SYM_BITS wide) indexes the chip within the symbol.
- Priority: reset > ppmd_restart > chip_en.
- On ppmd_restart:
  - chip_cnt := 1; buf[0] := fd_o.
  - Serial emission is aborted: bits_left := 0, ppmd_o := 0.
  - Registered flags stay 0; bad_cnt is unchanged.
- On chip_en with chip_cnt < CHIPS-1: buf[chip_cnt] := fd_o; chip_cnt increments.
- On chip_en with chip_cnt == CHIPS-1 (decode edge):
  - pattern = {buf[0..CHIPS-2], fd_o}, where chip 0 is the earliest chip. The current fd_o is used directly and is not buffered.
  - Exactly one chip set at position k: sym = k, bad = 0.
  - Otherwise (zero or several chips set): sym = 0, bad = 1.
  - At this edge: ppmd_sym := sym; ppmd_sym_valid := 1; ppmd_bad_chip := bad; chip_cnt wraps to 0.
  - If bad: bad_cnt increments, saturating at all-ones.
  - Serial shifter is loaded with sym. Its first bit (LSB if lsb_first, else MSB) drives ppmd_o at this same edge, with ppmd_bit_valid := 1 and bits_left := SYM_BITS-1.
- Serial emission continues on each later chip_en with bits_left > 0: next bit to ppmd_o, ppmd_bit_valid := 1, bits_left decrements.
  - The shifter is never busy at the next decode, because SYM_BITS <= CHIPS.
  - ppmd_o holds its value between strobes.
- Outside the edges above, ppmd_sym_valid, ppmd_bad_chip and ppmd_bit_valid are 0. ppmd_sym holds its value.
- bad_cnt_clr asserted in the same cycle as a bad decode gives bad_cnt := 1 (clear, then count). bad_cnt_clr alone gives bad_cnt := 0.
- Latency: symbol and first serial bit are visible one clk after the decode-edge chip_en. The last serial bit follows SYM_BITS-1 chip_en strobes later.
- chip_en low: no state changes, except bad_cnt_clr.

Decomposition:
- Package irda_ppm_pkg holds:
  - function clog2;
  - constant IRDA_4PPM_CHIPS = 4;
  - constant IRDA_16PPM_CHIPS = 16.
- Sub-module irda_ppm_onehot_dec (parameter CHIPS), purely combinational: pattern[CHIPS-1:0] in, sym[SYM_BITS-1:0] and onehot out. Instantiated once.
- All sequencing (counter, buffer, shifter, counter saturation) lives in the top module.

Test Plan:
- CHIPS=4, lsb_first=1, restart, then chips 0,0,1,0 on chip_en:
  - ppmd_sym=2, ppmd_bad_chip=0;
  - ppmd_o sequence 0,1 on two ppmd_bit_valid pulses.
- CHIPS=4, chips 1,1,0,0:
  - ppmd_bad_chip=1 pulse, ppmd_sym=0, bad_cnt=1;
  - serial bits 0,0.
- CHIPS=16, lsb_first=0, chip 13 set, all others 0:
  - ppmd_sym=13;
  - ppmd_o 1,1,0,1 on four consecutive chip_en.
- Mid-symbol ppmd_restart after 2 chips, asserted together with chip_en:
  - restart wins; that fd_o becomes chip 0;
  - decode occurs 3 further chip_en later; pending serial bits dropped.
- ERR_W=2, five bad symbols:
  - bad_cnt saturates at 3.
  - bad_cnt_clr coincident with a sixth bad symbol: bad_cnt=1.
- wb_rst_i asserted mid-serial-emission:
  - all outputs 0 on the next clk;
  - first decode after release occurs on the CHIPS-th chip_en.

Source files
------------

// File: rtl/irda_ppm_pkg.sv
// irda_ppm_pkg: shared constants and width helper for the L-PPM receive path.
package irda_ppm_pkg;

    localparam int IRDA_4PPM_CHIPS  = 4;
    localparam int IRDA_16PPM_CHIPS = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/irda_ppm_onehot_dec.sv
// irda_ppm_onehot_dec: maps a one-hot chip pattern to its symbol index; non-one-hot gives 0.
import irda_ppm_pkg::*;

module irda_ppm_onehot_dec #(
    parameter int  CHIPS    = IRDA_4PPM_CHIPS,
    localparam int SYM_BITS = clog2(CHIPS)
) (
    input  logic [CHIPS-1:0]    pattern,
    output logic [SYM_BITS-1:0] sym,
    output logic                onehot
);

    logic [SYM_BITS-1:0] idx;

    always_comb begin
        idx = '0;
        for (int i = 0; i < CHIPS; i++) if (pattern[i]) idx = SYM_BITS'(i);
    end

    assign onehot = (pattern != '0) && ((pattern & (pattern - CHIPS'(1))) == '0);
    assign sym    = onehot ? idx : '0;

endmodule

// File: rtl/irda_fir_lppm_decoder.sv
// irda_fir_lppm_decoder: collects CHIPS chips per symbol, decodes L-PPM and
// emits the symbol in parallel and as a serial bit stream.
import irda_ppm_pkg::*;

module irda_fir_lppm_decoder #(
    parameter int  CHIPS    = IRDA_4PPM_CHIPS,
    parameter int  ERR_W    = 8,
    localparam int SYM_BITS = clog2(CHIPS)
) (
    input  logic                clk,
    input  logic                wb_rst_i,
    input  logic                chip_en,
    input  logic                ppmd_restart,
    input  logic                fd_o,
    input  logic                lsb_first,
    input  logic                bad_cnt_clr,
    output logic [SYM_BITS-1:0] ppmd_sym,
    output logic                ppmd_sym_valid,
    output logic                ppmd_bad_chip,
    output logic                ppmd_o,
    output logic                ppmd_bit_valid,
    output logic [ERR_W-1:0]    bad_cnt
);

    localparam logic [SYM_BITS-1:0] LAST = SYM_BITS'(CHIPS - 1);

    logic [SYM_BITS-1:0] chip_cnt_q, chip_cnt_d;
    logic [CHIPS-2:0]    chip_buf_q, chip_buf_d;
    logic [SYM_BITS-1:0] shift_q, shift_d;
    logic [SYM_BITS-1:0] bits_left_q, bits_left_d;
    logic [SYM_BITS-1:0] sym_q, sym_d;
    logic                sym_valid_q, sym_valid_d;
    logic                bad_q, bad_d;
    logic                o_q, o_d;
    logic                bit_valid_q, bit_valid_d;
    logic [ERR_W-1:0]    bad_cnt_q, bad_cnt_d;
    logic [SYM_BITS-1:0] dec_sym, sym_rev, load;
    logic                onehot;

    irda_ppm_onehot_dec #(.CHIPS(CHIPS)) u_dec (
        .pattern ({fd_o, chip_buf_q}),
        .sym     (dec_sym),
        .onehot  (onehot)
    );

    // The shifter always emits bit 0, so MSB-first symbols are loaded reversed.
    assign sym_rev = {<<{dec_sym}};
    assign load    = lsb_first ? dec_sym : sym_rev;

    always_comb begin
        chip_cnt_d  = chip_cnt_q;
        chip_buf_d  = chip_buf_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        bad_d       = 1'b0;
        o_d         = o_q;
        bit_valid_d = 1'b0;
        bad_cnt_d   = bad_cnt_clr ? '0 : bad_cnt_q;
        if (ppmd_restart) begin
            chip_cnt_d    = SYM_BITS'(1);
            chip_buf_d[0] = fd_o;
            bits_left_d   = '0;
            o_d           = 1'b0;
        end else if (chip_en) begin
            if (chip_cnt_q == LAST) begin
                chip_cnt_d  = '0;
                sym_d       = dec_sym;
                sym_valid_d = 1'b1;
                bad_d       = !onehot;
                if (!onehot && bad_cnt_d != '1) bad_cnt_d = bad_cnt_d + ERR_W'(1);
                o_d         = load[0];
                shift_d     = load >> 1;
                bits_left_d = SYM_BITS'(SYM_BITS - 1);
                bit_valid_d = 1'b1;
            end else begin
                chip_buf_d[chip_cnt_q] = fd_o;
                chip_cnt_d             = chip_cnt_q + SYM_BITS'(1);
                if (bits_left_q != '0) begin
                    o_d         = shift_q[0];
                    shift_d     = shift_q >> 1;
                    bits_left_d = bits_left_q - SYM_BITS'(1);
                    bit_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            chip_cnt_q  <= '0;
            chip_buf_q  <= '0;
            shift_q     <= '0;
            bits_left_q <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            bad_q       <= 1'b0;
            o_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            bad_cnt_q   <= '0;
        end else begin
            chip_cnt_q  <= chip_cnt_d;
            chip_buf_q  <= chip_buf_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            bad_q       <= bad_d;
            o_q         <= o_d;
            bit_valid_q <= bit_valid_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign ppmd_sym       = sym_q;
    assign ppmd_sym_valid = sym_valid_q;
    assign ppmd_bad_chip  = bad_q;
    assign ppmd_o         = o_q;
    assign ppmd_bit_valid = bit_valid_q;
    assign bad_cnt        = bad_cnt_q;

endmodule

// File: tb/tb_irda_fir_lppm_decoder.sv
// tb_irda_fir_lppm_decoder: 4PPM (ERR_W=2) and 16PPM decoders on shared stimulus, checked against a chip-list model.
module tb_irda_fir_lppm_decoder;

    logic clk = 1'b0;
    logic wb_rst_i = 1'b0, chip_en = 1'b0, ppmd_restart = 1'b0, fd_o = 1'b0;
    logic lsb_first = 1'b1, bad_cnt_clr = 1'b0;

    logic [1:0] sym4;  logic sv4, bc4, o4, bv4;  logic [1:0] cnt4;
    logic [3:0] sym16; logic sv16, bc16, o16, bv16; logic [7:0] cnt16;

    int errs = 0, checks = 0;

    int   e_sym[2], e_cnt[2];
    logic e_sv[2], e_bc[2], e_o[2], e_bv[2];
    logic [15:0] m_pat[2];
    logic [3:0]  m_em[2];
    int m_n[2], m_nb[2], m_pos[2];

    wire [7:0]  obs4  = {sym4, sv4, bc4, o4, bv4, cnt4};
    wire [15:0] obs16 = {sym16, sv16, bc16, o16, bv16, cnt16};
    wire [7:0]  exp4  = {e_sym[0][1:0], e_sv[0], e_bc[0], e_o[0], e_bv[0], e_cnt[0][1:0]};
    wire [15:0] exp16 = {e_sym[1][3:0], e_sv[1], e_bc[1], e_o[1], e_bv[1], e_cnt[1][7:0]};

    always #5 clk = ~clk;

    irda_fir_lppm_decoder #(.CHIPS(4), .ERR_W(2)) u4 (
        .clk(clk), .wb_rst_i(wb_rst_i), .chip_en(chip_en), .ppmd_restart(ppmd_restart),
        .fd_o(fd_o), .lsb_first(lsb_first), .bad_cnt_clr(bad_cnt_clr),
        .ppmd_sym(sym4), .ppmd_sym_valid(sv4), .ppmd_bad_chip(bc4), .ppmd_o(o4),
        .ppmd_bit_valid(bv4), .bad_cnt(cnt4)
    );

    irda_fir_lppm_decoder #(.CHIPS(16), .ERR_W(8)) u16 (
        .clk(clk), .wb_rst_i(wb_rst_i), .chip_en(chip_en), .ppmd_restart(ppmd_restart),
        .fd_o(fd_o), .lsb_first(lsb_first), .bad_cnt_clr(bad_cnt_clr),
        .ppmd_sym(sym16), .ppmd_sym_valid(sv16), .ppmd_bad_chip(bc16), .ppmd_o(o16),
        .ppmd_bit_valid(bv16), .bad_cnt(cnt16)
    );

    // Reference: chips gathered per symbol, decoded by counting set chips, bits queued in emission order.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int ch, sb, mx, ones, k;
            logic [15:0] p;
            logic bad;
            ch = i ? 16 : 4; sb = i ? 4 : 2; mx = i ? 255 : 3;
            if (wb_rst_i) begin
                m_n[i] = 0; m_pat[i] = '0; m_nb[i] = 0; m_pos[i] = 0;
                e_sym[i] = 0; e_sv[i] = 0; e_bc[i] = 0; e_o[i] = 0; e_bv[i] = 0; e_cnt[i] = 0;
            end else begin
                bad = 1'b0; e_sv[i] = 0; e_bc[i] = 0; e_bv[i] = 0;
                if (ppmd_restart) begin
                    m_pat[i] = '0; m_pat[i][0] = fd_o; m_n[i] = 1; m_nb[i] = 0; e_o[i] = 0;
                end else if (chip_en) begin
                    if (m_n[i] == ch - 1) begin
                        p = m_pat[i]; p[ch-1] = fd_o;
                        ones = $countones(p); k = 0;
                        for (int j = 0; j < ch; j++) if (p[j]) k = j;
                        e_sym[i] = (ones == 1) ? k : 0;
                        bad = (ones != 1);
                        e_sv[i] = 1; e_bc[i] = bad;
                        for (int j = 0; j < sb; j++) m_em[i][j] = lsb_first ? e_sym[i][j] : e_sym[i][sb-1-j];
                        e_o[i] = m_em[i][0]; e_bv[i] = 1;
                        m_pos[i] = 1; m_nb[i] = sb - 1; m_n[i] = 0; m_pat[i] = '0;
                    end else begin
                        m_pat[i][m_n[i]] = fd_o; m_n[i]++;
                        if (m_nb[i] > 0) begin
                            e_o[i] = m_em[i][m_pos[i]]; m_pos[i]++; m_nb[i]--; e_bv[i] = 1;
                        end
                    end
                end
                if (bad_cnt_clr) e_cnt[i] = 0;
                if (bad && e_cnt[i] < mx) e_cnt[i]++;
            end
        end
    endtask

    task automatic drive(input logic en, input logic fd, input logic rs);
        chip_en = en; fd_o = fd; ppmd_restart = rs;
        @(posedge clk);
        model_step();
        #1;
        chip_en = 1'b0; ppmd_restart = 1'b0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (obs4 !== 8'h00) begin errs++; $display("FAIL reset4 got=%h want=00", obs4); end
        checks++; if (obs16 !== 16'h0000) begin errs++; $display("FAIL reset16 got=%h want=0000", obs16); end
    endtask

    task automatic test_sym2();
        do_reset();
        lsb_first = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({sym4, sv4, bc4, o4, bv4} !== 6'b10_1_0_0_1) begin errs++; $display("FAIL sym2_decode got=%b want=101001", {sym4, sv4, bc4, o4, bv4}); end
        checks++; if (obs4 !== exp4) begin errs++; $display("FAIL sym2_model got=%h want=%h", obs4, exp4); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({sv4, o4, bv4} !== 3'b011) begin errs++; $display("FAIL sym2_bit1 got=%b want=011", {sv4, o4, bv4}); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (bv4 !== 1'b0) begin errs++; $display("FAIL sym2_done got=%b want=0", bv4); end
    endtask

    task automatic test_bad();
        do_reset();
        lsb_first = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({sym4, sv4, bc4, o4, bv4, cnt4} !== 8'b00_1_1_0_1_01) begin errs++; $display("FAIL bad_decode got=%b want=00110101", obs4); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({o4, bv4, sv4, bc4} !== 4'b0100) begin errs++; $display("FAIL bad_bit1 got=%b want=0100", {o4, bv4, sv4, bc4}); end
    endtask

    task automatic test_16ppm();
        logic [3:0] want;
        do_reset();
        lsb_first = 1'b0;
        want = 4'b1101;
        drive(1'b0, 1'b0, 1'b1);
        for (int j = 1; j < 16; j++) drive(1'b1, j == 13, 1'b0);
        checks++; if ({sym16, sv16, bc16} !== 6'b1101_1_0) begin errs++; $display("FAIL ppm16_decode got=%b want=110110", {sym16, sv16, bc16}); end
        checks++; if ({o16, bv16} !== {want[3], 1'b1}) begin errs++; $display("FAIL ppm16_bit0 got=%b want=%b", {o16, bv16}, {want[3], 1'b1}); end
        for (int b = 1; b < 4; b++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++; if ({o16, bv16} !== {want[3-b], 1'b1}) begin errs++; $display("FAIL ppm16_bit%0d got=%b want=%b", b, {o16, bv16}, {want[3-b], 1'b1}); end
        end
        checks++; if (obs16 !== exp16) begin errs++; $display("FAIL ppm16_model got=%h want=%h", obs16, exp16); end
        lsb_first = 1'b1;
    endtask

    task automatic test_restart_mid();
        do_reset();
        lsb_first = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if ({sym4, sv4, o4, bv4} !== 5'b11_1_1_1) begin errs++; $display("FAIL rs_sym3 got=%b want=11111", {sym4, sv4, o4, bv4}); end
        drive(1'b1, 1'b1, 1'b1);
        checks++; if ({sv4, o4, bv4} !== 3'b000) begin errs++; $display("FAIL rs_abort got=%b want=000", {sv4, o4, bv4}); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({sv4, bv4} !== 2'b00) begin errs++; $display("FAIL rs_dropped got=%b want=00", {sv4, bv4}); end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({sym4, sv4, bc4} !== 4'b00_1_0) begin errs++; $display("FAIL rs_realign got=%b want=0010", {sym4, sv4, bc4}); end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (sv4 !== 1'b0) begin errs++; $display("FAIL rs_mid_early got=%b want=0", sv4); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({sym4, sv4, bc4} !== 4'b00_1_0) begin errs++; $display("FAIL rs_mid_decode got=%b want=0010", {sym4, sv4, bc4}); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 4; c++) begin
                bad_cnt_clr = (s == 5 && c == 3);
                drive(1'b1, 1'b0, 1'b0);
            end
            bad_cnt_clr = 1'b0;
            checks++;
            if ({bc4, cnt4} !== {1'b1, (s == 5) ? 2'd1 : ((s >= 2) ? 2'd3 : 2'(s + 1))}) begin
                errs++; $display("FAIL sat_sym%0d got=%b want_cnt=%0d", s, {bc4, cnt4}, (s == 5) ? 1 : ((s >= 2) ? 3 : s + 1));
            end
        end
        bad_cnt_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        bad_cnt_clr = 1'b0;
        checks++; if (cnt4 !== 2'd0) begin errs++; $display("FAIL sat_clear got=%0d want=0", cnt4); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lsb_first = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        wb_rst_i = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        wb_rst_i = 1'b0;
        checks++; if (obs4 !== 8'h00) begin errs++; $display("FAIL rstmid_clear got=%h want=00", obs4); end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if ({sv4, bv4} !== 2'b00) begin errs++; $display("FAIL rstmid_early got=%b want=00", {sv4, bv4}); end
        drive(1'b1, 1'b1, 1'b0);
        checks++; if ({sym4, sv4, bc4} !== 4'b11_1_0) begin errs++; $display("FAIL rstmid_decode got=%b want=1110", {sym4, sv4, bc4}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            wb_rst_i    = ($urandom_range(0, 299) == 0);
            lsb_first   = 1'($urandom_range(0, 1));
            bad_cnt_clr = ($urandom_range(0, 29) == 0);
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
            wb_rst_i = 1'b0; bad_cnt_clr = 1'b0;
            checks++; if (obs4 !== exp4) begin errs++; $display("FAIL rand4 cyc=%0d got=%h want=%h", n, obs4, exp4); end
            checks++; if (obs16 !== exp16) begin errs++; $display("FAIL rand16 cyc=%0d got=%h want=%h", n, obs16, exp16); end
        end
    endtask

    initial begin
        test_reset();
        test_sym2();
        test_bad();
        test_16ppm();
        test_restart_mid();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
